// File: rtl/ui_digit_blinker.sv
// ui_digit_blinker: registered one-hot digit-line decoder with an owned edit
// cursor and an internal blink-phase prescaler, so the cursor digit can flash
// at a slow or fast rate without an external slow clock.
module ui_digit_blinker #(
  parameter int unsigned NUM_DIGITS = 32,
  parameter int unsigned SEL_W      = 5,
  parameter int unsigned PRESCALE   = 25000,
  parameter int unsigned FAST_DIV   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  prog_running,
  input  logic [SEL_W-1:0]      digit_in,
  input  logic                  blink_en,
  input  logic                  fast_mode,
  input  logic                  cur_load,
  input  logic [SEL_W-1:0]      cur_load_val,
  input  logic                  cur_left,
  input  logic                  cur_right,
  output logic [SEL_W-1:0]      cursor,
  output logic                  blink_phase,
  output logic [NUM_DIGITS-1:0] digits_out
);

  // Counter only ever holds 0..PRESCALE-1 (fast limit is never larger).
  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [CNT_W-1:0] SLOW_LIM = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] FAST_LIM = CNT_W'((PRESCALE / FAST_DIV) - 1);
  localparam logic [SEL_W-1:0] LAST_DIG = SEL_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_n;
  logic                  phase_n;
  logic [SEL_W-1:0]      cursor_n;
  logic [NUM_DIGITS-1:0] digits_n;
  logic [CNT_W-1:0]      lim;
  logic                  load_acc;
  logic                  right_acc;
  logic                  left_acc;
  logic                  restart;
  logic                  show;
  logic                  in_range;

  // Cursor command acceptance: blocked entirely while a program runs.
  always_comb begin
    load_acc  = !prog_running && cur_load;
    right_acc = !prog_running && !cur_load && cur_right && !cur_left;
    left_acc  = !prog_running && !cur_load && cur_left && !cur_right;
    restart   = load_acc || right_acc || left_acc;
  end

  // Prescaler and blink phase next state; a cursor command restarts the
  // on-phase so the newly selected digit is visible immediately.
  always_comb begin
    lim     = fast_mode ? FAST_LIM : SLOW_LIM;
    cnt_n   = cnt + CNT_W'(1);
    phase_n = blink_phase;
    if (cnt == lim) begin
      cnt_n   = '0;
      phase_n = !blink_phase;
    end else if (cnt > lim) begin
      cnt_n = '0;
    end
    if (restart) begin
      cnt_n   = '0;
      phase_n = 1'b1;
    end
  end

  // Cursor next state: load (clamped), then wrap-around single-step moves.
  always_comb begin
    cursor_n = cursor;
    if (load_acc) begin
      cursor_n = (cur_load_val > LAST_DIG) ? LAST_DIG : cur_load_val;
    end else if (right_acc) begin
      cursor_n = (cursor == LAST_DIG) ? '0 : cursor + SEL_W'(1);
    end else if (left_acc) begin
      cursor_n = (cursor == '0) ? LAST_DIG : cursor - SEL_W'(1);
    end
  end

  // Digit enable decode against the pre-update cursor and phase.
  always_comb begin
    show     = prog_running || !blink_en || (digit_in != cursor) || blink_phase;
    in_range = 32'(digit_in) < NUM_DIGITS;
    digits_n = '0;
    if (show && in_range) begin
      digits_n = NUM_DIGITS'(1) << digit_in;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      blink_phase <= 1'b1;
      cursor      <= '0;
      digits_out  <= '0;
    end else begin
      cnt         <= cnt_n;
      blink_phase <= phase_n;
      cursor      <= cursor_n;
      digits_out  <= digits_n;
    end
  end

endmodule

// File: tb/tb_ui_digit_blinker.sv
// Directed self-checking bench for ui_digit_blinker (PRESCALE=4, FAST_DIV=2),
// with a second 10-digit instance for clamping and out-of-range decode.
module tb_ui_digit_blinker;

  logic        clk;
  logic        reset;
  logic        prog_running;
  logic [4:0]  digit_in;
  logic        blink_en;
  logic        fast_mode;
  logic        cur_load;
  logic [4:0]  cur_load_val;
  logic        cur_left;
  logic        cur_right;
  logic [4:0]  cursor;
  logic        blink_phase;
  logic [31:0] digits_out;

  logic [3:0]  b_digit_in;
  logic        b_cur_load;
  logic [3:0]  b_cur_load_val;
  logic [3:0]  b_cursor;
  logic        b_blink_phase;
  logic [9:0]  b_digits_out;

  int checks;
  int errors;

  ui_digit_blinker #(
    .NUM_DIGITS(32), .SEL_W(5), .PRESCALE(4), .FAST_DIV(2)
  ) dut (
    .clk(clk), .reset(reset), .prog_running(prog_running), .digit_in(digit_in),
    .blink_en(blink_en), .fast_mode(fast_mode), .cur_load(cur_load),
    .cur_load_val(cur_load_val), .cur_left(cur_left), .cur_right(cur_right),
    .cursor(cursor), .blink_phase(blink_phase), .digits_out(digits_out)
  );

  ui_digit_blinker #(
    .NUM_DIGITS(10), .SEL_W(4), .PRESCALE(4), .FAST_DIV(2)
  ) dut10 (
    .clk(clk), .reset(reset), .prog_running(1'b0), .digit_in(b_digit_in),
    .blink_en(1'b0), .fast_mode(1'b0), .cur_load(b_cur_load),
    .cur_load_val(b_cur_load_val), .cur_left(1'b0), .cur_right(1'b0),
    .cursor(b_cursor), .blink_phase(b_blink_phase), .digits_out(b_digits_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    prog_running = 1'b0;
    digit_in = 5'd0;
    blink_en = 1'b1;
    fast_mode = 1'b0;
    cur_load = 1'b0;
    cur_load_val = 5'd0;
    cur_left = 1'b0;
    cur_right = 1'b0;
    b_digit_in = 4'd0;
    b_cur_load = 1'b0;
    b_cur_load_val = 4'd0;

    // Reset state
    #2;
    chk("rst_cursor", 32'(cursor), 32'd0);
    chk("rst_phase", 32'(blink_phase), 32'd1);
    chk("rst_digits", digits_out, 32'd0);
    step();
    reset = 1'b0;

    // Slow blink: phase toggles every 4 edges, digits lag phase by one edge
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("slow_phase_%0d", k), 32'(blink_phase), 32'(((k / 4) % 2) == 0));
      chk($sformatf("slow_digits_%0d", k), digits_out, 32'(((k - 1) / 4) % 2 == 0));
    end

    // Fast blink from reset: 2-edge half-periods
    fast_mode = 1'b1;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("fast_phase_%0d", k), 32'(blink_phase), 32'(((k / 2) % 2) == 0));
    end

    // Switch to fast when count is 3: clears without toggling
    fast_mode = 1'b0;
    do_reset();
    steps(3);
    fast_mode = 1'b1;
    step(); chk("fsw_e4", 32'(blink_phase), 32'd1);
    step(); chk("fsw_e5", 32'(blink_phase), 32'd1);
    step(); chk("fsw_e6", 32'(blink_phase), 32'd0);
    step(); chk("fsw_e7", 32'(blink_phase), 32'd0);
    step(); chk("fsw_e8", 32'(blink_phase), 32'd1);
    fast_mode = 1'b0;

    // Cursor wrap and restart
    do_reset();
    cur_load = 1'b1; cur_load_val = 5'd31;
    step(); chk("load31", 32'(cursor), 32'd31);
    cur_load = 1'b0;
    steps(5);
    chk("pre_right_phase", 32'(blink_phase), 32'd0);
    cur_right = 1'b1;
    step(); chk("right_wrap", 32'(cursor), 32'd0);
    chk("right_restart", 32'(blink_phase), 32'd1);
    cur_right = 1'b0;
    steps(3); chk("restart_cnt_e3", 32'(blink_phase), 32'd1);
    step();   chk("restart_cnt_e4", 32'(blink_phase), 32'd0);
    cur_left = 1'b1;
    step(); chk("left_wrap", 32'(cursor), 32'd31);
    chk("left_restart", 32'(blink_phase), 32'd1);
    cur_left = 1'b0;
    steps(4); chk("pre_both_phase", 32'(blink_phase), 32'd0);
    cur_left = 1'b1; cur_right = 1'b1;
    step(); chk("both_cursor", 32'(cursor), 32'd31);
    chk("both_phase", 32'(blink_phase), 32'd0);
    cur_left = 1'b0; cur_right = 1'b0;
    cur_load = 1'b1; cur_load_val = 5'd7; cur_right = 1'b1;
    step(); chk("load7", 32'(cursor), 32'd7);
    cur_load = 1'b0; cur_right = 1'b0;

    // 10-digit instance: clamp and out-of-range decode
    b_cur_load = 1'b1; b_cur_load_val = 4'd15;
    step(); chk("n10_clamp", 32'(b_cursor), 32'd9);
    b_cur_load = 1'b0; b_digit_in = 4'd9;
    step(); chk("n10_d9", 32'(b_digits_out), 32'h200);
    b_digit_in = 4'd12;
    step(); chk("n10_d12", 32'(b_digits_out), 32'd0);

    // prog_running forces the cursor digit on and blocks commands
    do_reset();
    cur_load = 1'b1; cur_load_val = 5'd5;
    step(); chk("load5", 32'(cursor), 32'd5);
    cur_load = 1'b0;
    steps(4); chk("prog_pre_phase", 32'(blink_phase), 32'd0);
    digit_in = 5'd3;
    step(); chk("other_digit", digits_out, 32'h8);
    digit_in = 5'd5;
    step(); chk("cursor_dark", digits_out, 32'd0);
    prog_running = 1'b1; cur_right = 1'b1;
    step(); chk("prog_digits", digits_out, 32'h20);
    chk("prog_cursor", 32'(cursor), 32'd5);
    chk("prog_phase_c", 32'(blink_phase), 32'd0);
    cur_right = 1'b0;
    step(); chk("prog_phase_d", 32'(blink_phase), 32'd1);
    chk("prog_digits_d", digits_out, 32'h20);
    steps(3); chk("prog_phase_g", 32'(blink_phase), 32'd1);
    step();   chk("prog_phase_h", 32'(blink_phase), 32'd0);
    chk("prog_digits_h", digits_out, 32'h20);
    prog_running = 1'b0;

    // Asynchronous reset mid-count
    cur_load = 1'b1; cur_load_val = 5'd3; digit_in = 5'd0;
    step(); cur_load = 1'b0;
    steps(2);
    chk("pre_arst_cursor", 32'(cursor), 32'd3);
    chk("pre_arst_digits", digits_out, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("arst_cursor", 32'(cursor), 32'd0);
    chk("arst_phase", 32'(blink_phase), 32'd1);
    chk("arst_digits", digits_out, 32'd0);
    #1 reset = 1'b0;
    steps(3); chk("arst_cnt_e3", 32'(blink_phase), 32'd1);
    step();   chk("arst_cnt_e4", 32'(blink_phase), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ui_digit_blinker.md
Name: ui_digit_blinker

Overview:
- Parametrised, registered successor of the UI digit-line decoder for the numbotron front panel.
- Converts the display multiplexer's scan index into a one-hot digit-enable line.
- Owns the edit cursor register and an internal blink-phase generator, so the selected digit flashes at slow or fast rate without an external slow clock.
- Sits between the front-panel key decoder (cursor commands) and the display scan/driver logic.

Parameters:
- NUM_DIGITS, 32, number of digit lines driven (2..32).
- SEL_W, 5, width of scan index and cursor; must satisfy 2^SEL_W >= NUM_DIGITS.
- PRESCALE, 25000, clk cycles per blink half-period in slow mode (>= FAST_DIV).
- FAST_DIV, 4, fast-mode rate multiplier; fast half-period = PRESCALE/FAST_DIV cycles (integer divide).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- prog_running  in  1  program executing; forces the cursor digit steady on and blocks cursor commands.
- digit_in  in  SEL_W  digit index currently being scanned.
- blink_en  in  1  1 = selected digit blinks; 0 = all digits steady.
- fast_mode  in  1  1 = fast blink rate.
- cur_load  in  1  load cursor from cur_load_val.
- cur_load_val  in  SEL_W  cursor load value.
- cur_left  in  1  single-cycle pulse: move cursor down by one.
- cur_right  in  1  single-cycle pulse: move cursor up by one.
- cursor  out  SEL_W  current cursor position (registered).
- blink_phase  out  1  current blink phase; 1 = on.
- digits_out  out  NUM_DIGITS  registered one-hot digit enable.

Behaviour:
- Reset (async assert, released synchronously to clk): cursor=0, blink_phase=1, prescale counter=0, digits_out=0.
- Prescale counter limit L = fast_mode ? (PRESCALE/FAST_DIV - 1) : (PRESCALE - 1).
- Counter increments each cycle.
  - When count == L: count <= 0 and blink_phase toggles.
  - When count > L (fast_mode just asserted): count <= 0, no toggle.
- Cursor update, evaluated only when prog_running == 0, in priority order:
  - cur_load: cursor <= min(cur_load_val, NUM_DIGITS-1).
  - cur_right && !cur_left: cursor <= (cursor == NUM_DIGITS-1) ? 0 : cursor+1.
  - cur_left && !cur_right: cursor <= (cursor == 0) ? NUM_DIGITS-1 : cursor-1.
  - cur_left && cur_right without cur_load: no move, no restart.
- Blink restart: any accepted cursor command (load, or a single-direction move) sets count <= 0 and blink_phase <= 1 in the same edge. This overrides the prescaler toggle, so the newly selected digit is shown immediately.
- While prog_running == 1: cursor commands are ignored and cause no restart; the prescaler keeps running.
- Output enable: show = prog_running | !blink_en | (digit_in != cursor) | blink_phase.
  - digit_in and cursor are sampled on the same edge, using the pre-update cursor value.
- digits_out update each cycle: digits_out <= show && digit_in < NUM_DIGITS ? (1 << digit_in) : 0.
  - Latency: 1 clk from digit_in.
  - Out-of-range digit_in gives all zeros.
  - digits_out is never more than one-hot.
- blink_phase and cursor are direct register outputs, so a change is visible the cycle after its cause.

Test Plan:
- Reset, then cycles with PRESCALE=4, FAST_DIV=2, blink_en=1, digit_in=0, prog_running=0 -> digits_out=0x1 on the first edge; blink_phase toggles every 4 cycles; digits_out alternates 0x1 / 0x0 with 1-cycle lag.
- fast_mode=1 with the same stimulus -> phase toggles every 2 cycles. Raise fast_mode when count=3 -> count clears with no toggle, then 2-cycle half-periods.
- cursor=NUM_DIGITS-1 (31) plus a cur_right pulse -> cursor=0, blink_phase=1, count=0. A cur_left pulse at 0 -> cursor=31. cur_left and cur_right together -> cursor unchanged, phase unaffected.
- cur_load with val=7 -> cursor=7. With NUM_DIGITS=10, load val=15 -> cursor=9. digit_in=12 -> digits_out=0.
- prog_running=1 with blink_phase=0, digit_in=cursor=5 -> digits_out=0x20 steady; a cur_right pulse leaves cursor=5 and the phase sequence undisturbed.
- Assert reset mid-count with cursor=3 -> cursor, count, digits_out=0 and blink_phase=1 immediately, without waiting for a clock edge.
